// File: rtl/alu.sv
// Clocked ALU: add, subtract, NAND or XOR of two operands, registered with
// zero and carry/no-borrow flags one cycle after the operands are sampled.
module alu #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       op,
    output logic [WIDTH-1:0] out,
    output logic             zero,
    output logic             carry
);

    localparam logic [1:0] ADD  = 2'b00;
    localparam logic [1:0] SUB  = 2'b01;
    localparam logic [1:0] NAND = 2'b10;
    localparam logic [1:0] XOR  = 2'b11;

    logic [WIDTH:0]   sum_ext;
    logic [WIDTH-1:0] out_d, out_q;
    logic             zero_d, zero_q;
    logic             carry_d, carry_q;

    // Subtraction reuses the adder as a + ~b + 1, so its carry-out means "no borrow".
    always_comb begin
        sum_ext = '0;
        out_d   = '0;
        carry_d = 1'b0;
        case (op)
            ADD: begin
                sum_ext = {1'b0, a} + {1'b0, b};
                out_d   = sum_ext[WIDTH-1:0];
                carry_d = sum_ext[WIDTH];
            end
            SUB: begin
                sum_ext = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};
                out_d   = sum_ext[WIDTH-1:0];
                carry_d = sum_ext[WIDTH];
            end
            NAND: begin
                out_d = ~(a & b);
            end
            XOR: begin
                out_d = a ^ b;
            end
            default: begin
                out_d = '0;
            end
        endcase
        zero_d = (out_d == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q   <= '0;
            zero_q  <= 1'b0;
            carry_q <= 1'b0;
        end else begin
            out_q   <= out_d;
            zero_q  <= zero_d;
            carry_q <= carry_d;
        end
    end

    assign out   = out_q;
    assign zero  = zero_q;
    assign carry = carry_q;

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: directed cases, reset behaviour and
// randomized operations compared against an arithmetic reference model.
module tb_alu;

    localparam int WIDTH = 8;
    localparam int MOD   = 1 << WIDTH;

    logic             clk;
    logic             rst_n;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [1:0]       op;
    logic [WIDTH-1:0] out;
    logic             zero;
    logic             carry;

    int assertCount = 0;
    int failCount   = 0;

    alu #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .a     (a),
        .b     (b),
        .op    (op),
        .out   (out),
        .zero  (zero),
        .carry (carry)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports any mismatch.
    task automatic checkOutput(input string tag, input int observed, input int expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    // Reference model straight from the operation rules, using plain integers.
    task automatic refModel(input int av, input int bv, input int opv,
                            output int expOut, output int expZero, output int expCarry);
        int s;
        case (opv)
            0: begin
                s        = av + bv;
                expOut   = s % MOD;
                expCarry = (s >= MOD) ? 1 : 0;
            end
            1: begin
                expOut   = (av - bv + MOD) % MOD;
                expCarry = (av >= bv) ? 1 : 0;
            end
            2: begin
                expOut   = (MOD - 1) - (av & bv);
                expCarry = 0;
            end
            default: begin
                expOut   = av ^ bv;
                expCarry = 0;
            end
        endcase
        expZero = (expOut == 0) ? 1 : 0;
    endtask

    // Drive operands just after an edge, let the next edge capture them, then settle.
    task automatic applyStimulus(input int av, input int bv, input int opv);
        a  = WIDTH'(av);
        b  = WIDTH'(bv);
        op = 2'(opv);
        @(posedge clk);
        #1;
    endtask

    task automatic runOp(input string tag, input int av, input int bv, input int opv);
        int eo, ez, ec;
        applyStimulus(av, bv, opv);
        refModel(av, bv, opv, eo, ez, ec);
        checkOutput({tag, ".out"},   int'(out),   eo);
        checkOutput({tag, ".zero"},  int'(zero),  ez);
        checkOutput({tag, ".carry"}, int'(carry), ec);
    endtask

    initial begin
        int ra, rb, rop;

        rst_n = 1'b0;
        a     = '0;
        b     = '0;
        op    = 2'b00;
        #2;
        checkOutput("initReset.out",   int'(out),   0);
        checkOutput("initReset.zero",  int'(zero),  0);
        checkOutput("initReset.carry", int'(carry), 0);

        @(posedge clk);
        #1;
        checkOutput("holdReset.out",  int'(out),  0);
        checkOutput("holdReset.zero", int'(zero), 0);
        rst_n = 1'b1;

        // Load 0xFF, then assert reset mid-cycle and expect an immediate clear.
        runOp("loadFF", 0, 0, 2);
        checkOutput("loadFF.direct", int'(out), 'hFF);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("asyncReset.out",   int'(out),   0);
        checkOutput("asyncReset.zero",  int'(zero),  0);
        checkOutput("asyncReset.carry", int'(carry), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        runOp("subBorrow", 3, 5, 1);
        checkOutput("subBorrow.direct", int'(out), 'hFE);
        runOp("add", 3, 5, 0);
        checkOutput("add.direct", int'(out), 8);
        runOp("addOverflow", 'hFF, 1, 0);
        checkOutput("addOverflow.directCarry", int'(carry), 1);
        runOp("nand", 3, 5, 2);
        checkOutput("nand.direct", int'(out), 'hFE);
        runOp("subEqual", 3, 3, 1);
        checkOutput("subEqual.directZero", int'(zero), 1);
        runOp("subNoBorrow", 3, 2, 1);
        checkOutput("subNoBorrow.directOut", int'(out), 1);
        checkOutput("subNoBorrow.directZero", int'(zero), 0);
        runOp("xorSame", 'hA5, 'hA5, 3);
        checkOutput("xorSame.directZero", int'(zero), 1);
        runOp("subZeroMinusMax", 0, 'hFF, 1);
        runOp("addMaxMax", 'hFF, 'hFF, 0);

        // Inputs changing between edges must not disturb the held outputs.
        a  = 8'h10;
        b  = 8'h20;
        op = 2'b00;
        #2;
        checkOutput("holdBetweenEdges.out",   int'(out),   'hFE);
        checkOutput("holdBetweenEdges.carry", int'(carry), 1);
        @(posedge clk);
        #1;
        checkOutput("afterEdge.out", int'(out), 'h30);

        for (int i = 0; i < 300; i++) begin
            ra  = int'($urandom_range(MOD - 1, 0));
            rb  = int'($urandom_range(MOD - 1, 0));
            rop = int'($urandom_range(3, 0));
            if (i % 17 == 0) rb = ra;
            runOp($sformatf("rand%0d", i), ra, rb, rop);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
